// File: rtl/dcache_assoc_pkg.sv
// Shared definitions for the set-associative write-back data cache:
// controller state encoding, line geometry and address-field widths.
package dcache_assoc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_ALLOCATE  = 2'd2
    } state_e;

    localparam int LINE_W   = 256;
    localparam int WORD_W   = 32;
    localparam int OFFSET_W = 5;

    function automatic int index_bits(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_bits(input int addr_w, input int sets);
        return addr_w - OFFSET_W - $clog2(sets);
    endfunction

endpackage

// File: rtl/dcache_way.sv
// One way of the cache: valid/dirty/tag/data storage for every set,
// tag compare for the addressed set, store-word merge and line fill.
module dcache_way
    import dcache_assoc_pkg::*;
#(
    parameter int SETS   = 16,
    parameter int ADDR_W = 32
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [index_bits(SETS)-1:0]           index_i,
    input  logic [tag_bits(ADDR_W, SETS)-1:0]     tag_i,
    input  logic [2:0]                            word_sel_i,
    input  logic                                  wr_en_i,
    input  logic [WORD_W-1:0]                     wr_data_i,
    input  logic                                  fill_en_i,
    input  logic [LINE_W-1:0]                     fill_data_i,
    output logic                                  hit_o,
    output logic                                  valid_o,
    output logic                                  dirty_o,
    output logic [tag_bits(ADDR_W, SETS)-1:0]     tag_o,
    output logic [LINE_W-1:0]                     line_o,
    output logic [WORD_W-1:0]                     word_o
);

    localparam int TAG_W = tag_bits(ADDR_W, SETS);

    logic [SETS-1:0]   valid_q, valid_d;
    logic [SETS-1:0]   dirty_q, dirty_d;
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [LINE_W-1:0] data_q [SETS];

    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        if (fill_en_i) begin
            valid_d[index_i] = 1'b1;
            dirty_d[index_i] = 1'b0;
        end else if (wr_en_i) begin
            dirty_d[index_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Tags and line data are plain storage; only valid/dirty need a reset.
    always_ff @(posedge clk_i) begin
        if (fill_en_i) begin
            tag_q[index_i]  <= tag_i;
            data_q[index_i] <= fill_data_i;
        end else if (wr_en_i) begin
            data_q[index_i][{word_sel_i, 5'd0} +: WORD_W] <= wr_data_i;
        end
    end

    assign valid_o = valid_q[index_i];
    assign dirty_o = dirty_q[index_i];
    assign tag_o   = tag_q[index_i];
    assign line_o  = data_q[index_i];
    assign hit_o   = valid_o && (tag_o == tag_i);
    assign word_o  = line_o[{word_sel_i, 5'd0} +: WORD_W];

endmodule

// File: rtl/dcache_assoc.sv
// 1- or 2-way set-associative write-back data cache with LRU replacement.
// Define DCACHE_STATS_EN to add the hit_cnt_o / miss_cnt_o statistics ports.
module dcache_assoc
    import dcache_assoc_pkg::*;
#(
    parameter int WAYS   = 2,
    parameter int SETS   = 16,
    parameter int ADDR_W = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [ADDR_W-1:0]   address_i,
    input  logic [WORD_W-1:0]   write_data_i,
    input  logic                MemRead_i,
    input  logic                MemWrite_i,
    output logic [WORD_W-1:0]   read_data_o,
    input  logic [LINE_W-1:0]   mem_data_i,
    input  logic                mem_ack_i,
    output logic [LINE_W-1:0]   mem_data_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic                mem_enable_o,
    output logic                mem_write_o,
`ifdef DCACHE_STATS_EN
    output logic [31:0]         hit_cnt_o,
    output logic [31:0]         miss_cnt_o,
`endif
    output logic                mem_stall
);

    localparam int IDX_W = index_bits(SETS);
    localparam int TAG_W = tag_bits(ADDR_W, SETS);

    logic [IDX_W-1:0] index;
    logic [TAG_W-1:0] req_tag;
    logic [2:0]       word_sel;
    logic             unused_addr_bits;

    assign word_sel         = address_i[4:2];
    assign index            = address_i[OFFSET_W +: IDX_W];
    assign req_tag          = address_i[ADDR_W-1 -: TAG_W];
    assign unused_addr_bits = ^address_i[1:0];

    logic [WAYS-1:0]              hit_w, valid_w, dirty_w, wr_en_w, fill_en_w;
    logic [WAYS-1:0][TAG_W-1:0]   tag_w;
    logic [WAYS-1:0][LINE_W-1:0]  line_w;
    logic [WAYS-1:0][WORD_W-1:0]  word_w;

    state_e             state_q;
    logic               victim_q;
    logic               mem_enable_q, mem_write_q;
    logic [ADDR_W-1:0]  mem_addr_q;
    logic [LINE_W-1:0]  mem_data_q;
    logic [SETS-1:0]    lru_q, lru_d;

    logic req, hit_any, hit_way, lookup_hit, lookup_miss, fill_any, victim_sel;

    assign req         = MemRead_i || MemWrite_i;
    assign hit_any     = |hit_w;
    assign hit_way     = (WAYS == 2) ? !hit_w[0] : 1'b0;
    assign lookup_hit  = (state_q == ST_IDLE) && req && hit_any;
    assign lookup_miss = (state_q == ST_IDLE) && req && !hit_any;
    assign fill_any    = !rst_i && (state_q == ST_ALLOCATE) && mem_ack_i;

    genvar w;
    generate
        for (w = 0; w < WAYS; w++) begin : g_way
            assign wr_en_w[w]   = !rst_i && lookup_hit && MemWrite_i && hit_w[w];
            assign fill_en_w[w] = fill_any && (victim_q == 1'(w));

            dcache_way #(
                .SETS   (SETS),
                .ADDR_W (ADDR_W)
            ) u_way (
                .clk_i       (clk_i),
                .rst_i       (rst_i),
                .index_i     (index),
                .tag_i       (req_tag),
                .word_sel_i  (word_sel),
                .wr_en_i     (wr_en_w[w]),
                .wr_data_i   (write_data_i),
                .fill_en_i   (fill_en_w[w]),
                .fill_data_i (mem_data_i),
                .hit_o       (hit_w[w]),
                .valid_o     (valid_w[w]),
                .dirty_o     (dirty_w[w]),
                .tag_o       (tag_w[w]),
                .line_o      (line_w[w]),
                .word_o      (word_w[w])
            );
        end
    endgenerate

    // Prefer an empty way (way 0 first); only a full set consults LRU.
    always_comb begin
        victim_sel = 1'b0;
        if (WAYS == 2) begin
            if (!valid_w[0])
                victim_sel = 1'b0;
            else if (!valid_w[WAYS-1])
                victim_sel = 1'b1;
            else
                victim_sel = lru_q[index];
        end
    end

    always_comb begin
        lru_d = lru_q;
        if (lookup_hit)
            lru_d[index] = !hit_way;
        else if (fill_any)
            lru_d[index] = !victim_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            victim_q     <= 1'b0;
            mem_enable_q <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            lru_q        <= '0;
        end else begin
            lru_q <= lru_d;
            case (state_q)
                ST_IDLE: begin
                    if (lookup_miss) begin
                        victim_q     <= victim_sel;
                        mem_enable_q <= 1'b1;
                        if (valid_w[victim_sel] && dirty_w[victim_sel]) begin
                            state_q     <= ST_WRITEBACK;
                            mem_write_q <= 1'b1;
                            mem_addr_q  <= {tag_w[victim_sel], index, 5'd0};
                            mem_data_q  <= line_w[victim_sel];
                        end else begin
                            state_q     <= ST_ALLOCATE;
                            mem_write_q <= 1'b0;
                            mem_addr_q  <= {req_tag, index, 5'd0};
                        end
                    end
                end
                ST_WRITEBACK: begin
                    if (mem_ack_i) begin
                        state_q     <= ST_ALLOCATE;
                        mem_write_q <= 1'b0;
                        mem_addr_q  <= {req_tag, index, 5'd0};
                    end
                end
                ST_ALLOCATE: begin
                    if (mem_ack_i) begin
                        state_q      <= ST_IDLE;
                        mem_enable_q <= 1'b0;
                        mem_addr_q   <= '0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign mem_enable_o = mem_enable_q;
    assign mem_write_o  = mem_write_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_data_o   = mem_data_q;
    assign mem_stall    = (state_q != ST_IDLE) || lookup_miss;
    assign read_data_o  = ((state_q == ST_IDLE) && MemRead_i && hit_any) ? word_w[hit_way] : '0;

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q + {31'd0, lookup_hit};
        miss_cnt_d = miss_cnt_q + {31'd0, lookup_miss};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_assoc.sv
// Directed bench for dcache_assoc (WAYS=2, SETS=16): a word-level golden memory
// feeds a read-data scoreboard; a memory responder logs line transfers.
module tb_dcache_assoc;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [31:0]  address_i;
    logic [31:0]  write_data_i;
    logic         MemRead_i, MemWrite_i;
    logic [31:0]  read_data_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;
    logic [255:0] mem_data_o;
    logic [31:0]  mem_addr_o;
    logic         mem_enable_o, mem_write_o, mem_stall;

    always #5 clk_i = ~clk_i;

    dcache_assoc #(.WAYS(2), .SETS(16), .ADDR_W(32)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .address_i    (address_i),
        .write_data_i (write_data_i),
        .MemRead_i    (MemRead_i),
        .MemWrite_i   (MemWrite_i),
        .read_data_o  (read_data_o),
        .mem_data_i   (mem_data_i),
        .mem_ack_i    (mem_ack_i),
        .mem_data_o   (mem_data_o),
        .mem_addr_o   (mem_addr_o),
        .mem_enable_o (mem_enable_o),
        .mem_write_o  (mem_write_o),
        .mem_stall    (mem_stall)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0]  golden    [logic [31:0]];
    logic [255:0] mem_model [logic [31:0]];
    logic [31:0]  rd_sb [$];
    logic [32:0]  txn_q [$];

    int mem_lat       = 1;
    bit auto_mem      = 1'b1;
    int manual_pulses = 0;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        if (a == 32'h40) return 32'hDEADBEEF;
        return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction

    function automatic logic [31:0] gold_rd(input logic [31:0] a);
        return golden.exists(a) ? golden[a] : init_word(a);
    endfunction

    function automatic logic [255:0] mem_line(input logic [31:0] a);
        logic [255:0] l;
        if (mem_model.exists(a)) return mem_model[a];
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = init_word(a + 32'(i * 4));
        return l;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Memory responder: acks after mem_lat cycles of mem_enable_o, or on demand.
    initial begin
        int cnt  = 0;
        int seen = 0;
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
        forever begin
            @(negedge clk_i);
            if (mem_ack_i) mem_ack_i = 1'b0;
            if (manual_pulses != seen) begin
                seen       = manual_pulses;
                mem_ack_i  = 1'b1;
                mem_data_i = '0;
            end else if (auto_mem && mem_enable_o) begin
                cnt++;
                if (cnt >= mem_lat) begin
                    cnt       = 0;
                    mem_ack_i = 1'b1;
                    txn_q.push_back({mem_write_o, mem_addr_o});
                    if (mem_write_o) mem_model[mem_addr_o] = mem_data_o;
                    else             mem_data_i = mem_line(mem_addr_o);
                end
            end
        end
    end

    task automatic access(input string nm, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] wd, input int exp_cycles);
        int cyc;
        logic [31:0] exp_rd;
        address_i    = a;
        MemRead_i    = rd;
        MemWrite_i   = wr;
        write_data_i = wd;
        if (rd) rd_sb.push_back(gold_rd(a));
        if (wr) golden[a] = wd;
        #1;
        check({nm, "_stall_first"}, 64'(mem_stall), 64'(exp_cycles != 0));
        cyc = 0;
        while (mem_stall === 1'b1 && cyc < 500) begin
            @(negedge clk_i);
            #1;
            cyc++;
        end
        check({nm, "_stall_cycles"}, 64'(cyc), 64'(exp_cycles));
        if (rd) begin
            exp_rd = rd_sb.pop_front();
            check({nm, "_rdata"}, 64'(read_data_o), 64'(exp_rd));
        end
        @(negedge clk_i);
        MemRead_i  = 1'b0;
        MemWrite_i = 1'b0;
    endtask

    task automatic check_txn(input string nm, input int n, input logic [32:0] t0, input logic [32:0] t1);
        check({nm, "_txn_count"}, 64'(txn_q.size()), 64'(n));
        if (n >= 1 && txn_q.size() >= 1) check({nm, "_txn0"}, 64'(txn_q[0]), 64'(t0));
        if (n >= 2 && txn_q.size() >= 2) check({nm, "_txn1"}, 64'(txn_q[1]), 64'(t1));
        txn_q.delete();
    endtask

    initial begin
        rst_i        = 1'b1;
        address_i    = '0;
        write_data_i = '0;
        MemRead_i    = 1'b0;
        MemWrite_i   = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check("rst_mem_enable", 64'(mem_enable_o), 64'(0));
        check("rst_mem_write",  64'(mem_write_o),  64'(0));
        check("rst_mem_addr",   64'(mem_addr_o),   64'(0));
        check("rst_mem_data",   64'(mem_data_o == '0), 64'(1));
        check("rst_stall",      64'(mem_stall),    64'(0));
        check("rst_rdata",      64'(read_data_o),  64'(0));
        @(negedge clk_i);

        mem_lat = 1;
        access("ld40", 1'b1, 1'b0, 32'h40, 32'h0, 2);
        check_txn("ld40", 1, {1'b0, 32'h40}, '0);
        access("st44", 1'b0, 1'b1, 32'h44, 32'h12345678, 0);
        check_txn("st44", 0, '0, '0);
        access("ld44", 1'b1, 1'b0, 32'h44, 32'h0, 0);
        access("rw48", 1'b1, 1'b1, 32'h48, 32'hA5A50048, 0);
        access("ld48", 1'b1, 1'b0, 32'h48, 32'h0, 0);

        mem_lat = 3;
        access("ld240", 1'b1, 1'b0, 32'h240, 32'h0, 4);
        check_txn("ld240", 1, {1'b0, 32'h240}, '0);
        access("st240", 1'b0, 1'b1, 32'h240, 32'hCAFEF00D, 0);
        access("ld40_touch", 1'b1, 1'b0, 32'h40, 32'h0, 0);
        access("ld440", 1'b1, 1'b0, 32'h440, 32'h0, 7);
        check_txn("ld440", 2, {1'b1, 32'h240}, {1'b0, 32'h440});

        mem_lat = 2;
        access("ld240_again", 1'b1, 1'b0, 32'h240, 32'h0, 5);
        check_txn("ld240_again", 2, {1'b1, 32'h40}, {1'b0, 32'h240});
        access("ld2a4", 1'b1, 1'b0, 32'h2A4, 32'h0, 3);
        check_txn("ld2a4", 1, {1'b0, 32'h2A0}, '0);

        manual_pulses++;
        repeat (3) @(negedge clk_i);
        #1;
        check("stray_ack_enable", 64'(mem_enable_o), 64'(0));
        check("stray_ack_stall",  64'(mem_stall),    64'(0));
        check_txn("stray_ack", 0, '0, '0);
        access("ld2a4_hit", 1'b1, 1'b0, 32'h2A4, 32'h0, 0);

        auto_mem   = 1'b0;
        address_i  = 32'h80;
        MemRead_i  = 1'b1;
        repeat (2) @(negedge clk_i);
        #1;
        check("alloc_enable", 64'(mem_enable_o), 64'(1));
        check("alloc_write",  64'(mem_write_o),  64'(0));
        check("alloc_addr",   64'(mem_addr_o),   64'(32'h80));
        check("alloc_stall",  64'(mem_stall),    64'(1));
        @(negedge clk_i);
        rst_i     = 1'b1;
        MemRead_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        manual_pulses++;
        repeat (3) @(negedge clk_i);
        #1;
        check("post_rst_enable", 64'(mem_enable_o), 64'(0));
        check("post_rst_stall",  64'(mem_stall),    64'(0));
        check("post_rst_addr",   64'(mem_addr_o),   64'(0));
        auto_mem = 1'b1;
        mem_lat  = 1;
        @(negedge clk_i);
        access("ld40_post_rst", 1'b1, 1'b0, 32'h40, 32'h0, 2);
        check_txn("ld40_post_rst", 1, {1'b0, 32'h40}, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dcache_assoc.md
DCACHE_ASSOC -- requirements
Module: dcache_assoc

Interface
REQ-001 Parameter WAYS, default 2, associativity; legal values 1 or 2.
REQ-002 Parameter SETS, default 16, sets per way; power of two, 2..256.
REQ-003 Parameter ADDR_W, default 32, byte-address width; line fixed at 256 bits (8 x 32-bit words).
REQ-004 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_i  in  1  reset; synchronous, active-high.
REQ-006 address_i  in  ADDR_W  CPU byte address; [4:2] word select, next log2(SETS) bits index, remainder tag.
REQ-007 write_data_i  in  32  CPU store data.
REQ-008 MemRead_i / MemWrite_i  in  1 each  CPU load/store request, level, held while mem_stall is high.
REQ-009 read_data_o  out  32  load data, valid when MemRead_i=1 and mem_stall=0.
REQ-010 mem_stall  out  1  pipeline freeze while a miss is serviced.
REQ-011 mem_data_i  in  256  line from memory; mem_ack_i  in  1  one-cycle completion pulse.
REQ-012 mem_data_o  out  256, mem_addr_o  out  ADDR_W (32-byte aligned), mem_enable_o  out  1, mem_write_o  out  1.

Function
REQ-013 FSM states IDLE, WRITEBACK, ALLOCATE.
REQ-014 IDLE lookup is combinational: hit = valid && tag match in any way; hit never asserts mem_stall.
REQ-015 Load hit: read_data_o = selected word of hit way in the same cycle; LRU updated at the edge.
REQ-016 Store hit: word written and dirty set at the edge; other seven words unchanged.
REQ-017 MemRead_i and MemWrite_i both high: treated as store; read_data_o returns the pre-write word.
REQ-018 Miss in IDLE: mem_stall=1 combinationally that cycle; victim = first invalid way (way 0 first), else LRU way.
REQ-019 Victim valid and dirty -> WRITEBACK, else -> ALLOCATE.
REQ-020 WRITEBACK: mem_enable_o=1, mem_write_o=1, mem_addr_o={victim tag, index, 5'b0}, mem_data_o=victim line, all held stable; on mem_ack_i -> ALLOCATE.
REQ-021 ALLOCATE: mem_enable_o=1, mem_write_o=0, mem_addr_o={req tag, index, 5'b0}; on mem_ack_i install mem_data_i into victim way, valid=1, dirty=0, tag set, -> IDLE.
REQ-022 After fill the request re-evaluates in IDLE next cycle as a hit; mem_stall deasserts that cycle; minimum miss penalty = memory latency + 1.
REQ-023 mem_stall=1 in WRITEBACK and ALLOCATE regardless of mem_ack_i.
REQ-024 LRU bit per set (WAYS=2) points at the way not most recently hit or filled; ignored when WAYS=1.
REQ-025 mem_ack_i while mem_enable_o=0 is ignored.
REQ-026 No request (both strobes low): no state, LRU or memory activity.

Reset
REQ-027 On rst_i: state=IDLE, all valid, dirty and LRU bits cleared; line data and tags need not clear.
REQ-028 Outputs at reset: mem_enable_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0, mem_stall=0, read_data_o=0.
REQ-029 Reset mid-WRITEBACK/ALLOCATE abandons the transfer; a later mem_ack_i is ignored.

Configuration
REQ-030 DCACHE_STATS_EN defined: 32-bit outputs hit_cnt_o and miss_cnt_o; hit_cnt_o counts IDLE hits, miss_cnt_o counts IDLE->miss transitions (one per miss, not per stall cycle); cleared by reset, wrap at 2^32.
REQ-031 DCACHE_STATS_EN undefined: ports and counters absent; all other behaviour identical.

Structure
REQ-032 Shared package holds FSM state encoding, LINE_W=256, WORD_W=32, OFFSET_W=5, and the address-field width functions.
REQ-033 One sub-module dcache_way (tag/valid/dirty/data arrays for one way, hit compare, word write); instantiated WAYS times.

Verification
REQ-034 Reset, then load 0x00000040 -> mem_stall=1, ALLOCATE read at 0x40; ack with line word0=0xDEADBEEF -> next cycle read_data_o=0xDEADBEEF, mem_stall=0.
REQ-035 Store 0x12345678 to 0x44 after REQ-034 -> no stall; load 0x44 -> 0x12345678.
REQ-036 SETS=16, WAYS=2: fill tags for 0x040, 0x240, touch 0x040, load 0x440 -> way of 0x240 evicted; if dirty, WRITEBACK at 0x240 precedes ALLOCATE at 0x440.
REQ-037 Assert rst_i during ALLOCATE, then pulse mem_ack_i -> mem_enable_o=0, state IDLE, load 0x40 misses again.
REQ-038 DCACHE_STATS_EN defined: 3 hits, 2 misses (second with 10-cycle ack delay) -> hit_cnt_o=3 (+2 post-fill hits =5), miss_cnt_o=2.
REQ-039 WAYS=1, SETS=2: loads to 0x00, 0x40, 0x00 -> three misses, no WRITEBACK (lines clean).
